// File: rtl/noc_vc_out_scheduler.sv
// noc_vc_out_scheduler
//
// Shares the tile's single NoC output flit bus between VCHANNELS virtual-channel
// requesters. One VC is picked per packet by round robin and held until the
// packet's LAST flit. The chosen flit is registered in a one-entry output buffer
// that can drain and reload in the same cycle, so back-to-back flits flow at one
// per cycle.
//
// Flit type lives in the top NOC_FLIT_TYPE_WIDTH bits of each flit:
//   00 PAYLOAD, 01 HEADER, 10 LAST, 11 SINGLE
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   in_flit    per-VC flits, VC i at [(i+1)*NOC_FLIT_WIDTH-1 : i*NOC_FLIT_WIDTH]
//   in_valid   per-VC flit valid
//   in_ready   per-VC accept, at most one bit high (combinational)
//   out_flit   buffered flit towards the NoC
//   out_valid  one-hot VC tag of out_flit, all-zero when the buffer is empty
//   out_ready  per-VC downstream ready
//   err_proto  one-cycle pulse after a flit of the wrong type was accepted
//
// Build option
//   NOC_VC_SCHED_FIXPRIO_EN : VC 0 wins idle arbitration whenever it is valid;
//                             the other VCs share round robin. A locked packet is
//                             never preempted.
//
// in_ready depends combinationally on out_ready (buffer draining frees the slot
// in the same cycle); this path is intentional.

module noc_vc_out_scheduler #(
    parameter int NOC_FLIT_DATA_WIDTH = 32,
    parameter int NOC_FLIT_TYPE_WIDTH = 2,
    parameter int VCHANNELS           = 3,
    localparam int NOC_FLIT_WIDTH     = NOC_FLIT_DATA_WIDTH + NOC_FLIT_TYPE_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [VCHANNELS*NOC_FLIT_WIDTH-1:0] in_flit,
    input  logic [VCHANNELS-1:0]                in_valid,
    output logic [VCHANNELS-1:0]                in_ready,
    output logic [NOC_FLIT_WIDTH-1:0]           out_flit,
    output logic [VCHANNELS-1:0]                out_valid,
    input  logic [VCHANNELS-1:0]                out_ready,
    output logic                                err_proto
);

    localparam int VC_W = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

    localparam logic [NOC_FLIT_TYPE_WIDTH-1:0] FLIT_PAYLOAD = NOC_FLIT_TYPE_WIDTH'(0);
    localparam logic [NOC_FLIT_TYPE_WIDTH-1:0] FLIT_HEADER  = NOC_FLIT_TYPE_WIDTH'(1);
    localparam logic [NOC_FLIT_TYPE_WIDTH-1:0] FLIT_LAST    = NOC_FLIT_TYPE_WIDTH'(2);
    localparam logic [NOC_FLIT_TYPE_WIDTH-1:0] FLIT_SINGLE  = NOC_FLIT_TYPE_WIDTH'(3);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t                         state_q, state_d;
    logic [VC_W-1:0]                lock_vc_q, lock_vc_d;
    logic [VC_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [VC_W-1:0]                gnt_vc;
    logic                           gnt_found;
    logic                           buf_drain;
    logic                           buf_can_load;
    logic                           accept;
    logic                           proto_bad;
    logic [NOC_FLIT_WIDTH-1:0]      flit_arr [VCHANNELS];
    logic [NOC_FLIT_WIDTH-1:0]      sel_flit;
    logic [NOC_FLIT_TYPE_WIDTH-1:0] sel_type;

    function automatic logic [VC_W-1:0] next_vc(input logic [VC_W-1:0] v);
        if (int'(v) >= VCHANNELS - 1) begin
            return '0;
        end
        return v + VC_W'(1);
    endfunction

    for (genvar i = 0; i < VCHANNELS; i++) begin : g_split
        assign flit_arr[i] = in_flit[i*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH];
    end

    // The buffer may take a new flit when it is empty or emptying this cycle.
    assign buf_drain    = |(out_valid & out_ready);
    assign buf_can_load = ~(|out_valid) | buf_drain;

    // Candidate selection: the locked VC, or a rotating search from rr_ptr.
    always_comb begin
        int              idx;
        logic [VC_W-1:0] idx_v;
        gnt_found = 1'b0;
        gnt_vc    = '0;
        idx       = 0;
        idx_v     = '0;
        if (state_q == ST_LOCKED) begin
            gnt_found = in_valid[lock_vc_q];
            gnt_vc    = lock_vc_q;
        end else begin
`ifdef NOC_VC_SCHED_FIXPRIO_EN
            if (in_valid[0]) begin
                gnt_found = 1'b1;
                gnt_vc    = '0;
            end
`endif
            for (int k = 0; k < VCHANNELS; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= VCHANNELS) begin
                    idx = idx - VCHANNELS;
                end
                idx_v = VC_W'(idx);
                if (!gnt_found && in_valid[idx_v]) begin
                    gnt_found = 1'b1;
                    gnt_vc    = idx_v;
                end
            end
        end
    end

    // in_ready is held low while reset is asserted so nothing is offered an
    // accept that the registers would immediately discard.
    always_comb begin
        in_ready = '0;
        if (!rst && gnt_found && buf_can_load) begin
            in_ready[gnt_vc] = 1'b1;
        end
    end

    assign accept   = !rst && gnt_found && buf_can_load;
    assign sel_flit = flit_arr[gnt_vc];
    assign sel_type = sel_flit[NOC_FLIT_WIDTH-1 -: NOC_FLIT_TYPE_WIDTH];

    // Lock / round-robin next state; nothing moves without an accepted flit.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        proto_bad = 1'b0;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                if (sel_type == FLIT_HEADER) begin
                    state_d   = ST_LOCKED;
                    lock_vc_d = gnt_vc;
                end else if (sel_type == FLIT_PAYLOAD || sel_type == FLIT_LAST) begin
                    // Stray body flit: forwarded as if it were SINGLE.
                    proto_bad = 1'b1;
                end
`ifdef NOC_VC_SCHED_FIXPRIO_EN
                if (gnt_vc != '0) begin
                    rr_ptr_d = next_vc(gnt_vc);
                end
`else
                rr_ptr_d = next_vc(gnt_vc);
`endif
            end else begin
                if (sel_type == FLIT_LAST) begin
                    state_d = ST_IDLE;
                end else if (sel_type == FLIT_HEADER || sel_type == FLIT_SINGLE) begin
                    // Misplaced packet start inside a packet: kept as PAYLOAD.
                    proto_bad = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lock_vc_q <= '0;
            rr_ptr_q  <= '0;
            err_proto <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            rr_ptr_q  <= rr_ptr_d;
            err_proto <= proto_bad;
        end
    end

    // Output buffer: load wins over drain so a handover keeps out_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            out_flit  <= '0;
        end else if (accept) begin
            out_valid <= in_ready;
            out_flit  <= sel_flit;
        end else if (buf_drain) begin
            out_valid <= '0;
        end
    end

endmodule

// File: tb/tb_noc_vc_out_scheduler.sv
`timescale 1ns/1ps
module tb_noc_vc_out_scheduler;

    localparam int DW = 32;
    localparam int TW = 2;
    localparam int N  = 3;
    localparam int FW = DW + TW;
    localparam int IW = N * FW;

    localparam logic [1:0] T_PAY  = 2'b00;
    localparam logic [1:0] T_HDR  = 2'b01;
    localparam logic [1:0] T_LAST = 2'b10;
    localparam logic [1:0] T_SGL  = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] in_flit;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [FW-1:0] out_flit;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready;
    logic          err_proto;

    noc_vc_out_scheduler #(
        .NOC_FLIT_DATA_WIDTH(DW),
        .NOC_FLIT_TYPE_WIDTH(TW),
        .VCHANNELS(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_flit(in_flit),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_flit(out_flit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus sources and scoreboard
    logic [FW-1:0] src_q  [N][$];
    logic [FW-1:0] sent_q [N][$];
    logic [FW-1:0] got_q  [N][$];
    int            tag_log[$];
    int            exp_tags[$];
    logic [N-1:0]  src_en;
    int            seq = 0;

    // Reference model state (rules of the scheduler, not its encoding)
    bit            m_locked;
    int            m_lock_vc;
    int            m_rr;
    bit            m_bvalid;
    int            m_bvc;
    logic [FW-1:0] m_bflit;
    bit            m_err;

    function automatic bit bitv(input logic [N-1:0] x, input int i);
        return ((x >> i) & N'(1)) != '0;
    endfunction

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int v, input int s);
        return {t, 8'(v), 24'(s)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked  = 0;
        m_lock_vc = 0;
        m_rr      = 0;
        m_bvalid  = 0;
        m_bvc     = 0;
        m_bflit   = '0;
        m_err     = 0;
    endtask

    task automatic enq(input int v, input logic [1:0] t);
        logic [FW-1:0] f;
        f = mk(t, v, seq);
        seq++;
        src_q[v].push_back(f);
        sent_q[v].push_back(f);
    endtask

    task automatic drive_inputs();
        in_valid = '0;
        in_flit  = '0;
        for (int v = 0; v < N; v++) begin
            if (bitv(src_en, v) && src_q[v].size() > 0) begin
                in_valid = in_valid | (N'(1) << v);
                in_flit  = in_flit | (IW'(src_q[v][0]) << (v * FW));
            end
        end
    endtask

    // One clock: drive, compare at the falling edge, then advance sources,
    // scoreboard and model on the rising edge.
    task automatic cycle();
        int            w;
        bit            found;
        bit            drain;
        bit            canld;
        logic [N-1:0]  exp_ready;
        logic [N-1:0]  exp_valid;
        logic [N-1:0]  acc_dut;
        logic [N-1:0]  drn_dut;
        logic [FW-1:0] obs_flit;
        logic [FW-1:0] f;
        logic [1:0]    t;
        int            c;
        drive_inputs();
        @(negedge clk);
        if (rst) model_reset();
        drain = m_bvalid && bitv(out_ready, m_bvc);
        canld = !m_bvalid || drain;
        found = 0;
        w     = 0;
        if (!rst) begin
            if (m_locked) begin
                if (bitv(in_valid, m_lock_vc)) begin
                    found = 1;
                    w     = m_lock_vc;
                end
            end else begin
`ifdef NOC_VC_SCHED_FIXPRIO_EN
                if (bitv(in_valid, 0)) begin
                    found = 1;
                    w     = 0;
                end
`endif
                for (int k = 0; k < N; k++) begin
                    c = (m_rr + k) % N;
                    if (!found && bitv(in_valid, c)) begin
                        found = 1;
                        w     = c;
                    end
                end
            end
        end
        exp_ready = (found && canld) ? (N'(1) << w) : '0;
        exp_valid = m_bvalid ? (N'(1) << m_bvc) : '0;
        check("in_ready",  64'(in_ready),  64'(exp_ready));
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("out_flit",  64'(out_flit),  64'(m_bflit));
        check("err_proto", 64'(err_proto), 64'(m_err));
        acc_dut  = in_valid & in_ready;
        drn_dut  = out_valid & out_ready;
        obs_flit = out_flit;
        @(posedge clk);
        for (int v = 0; v < N; v++) begin
            if (bitv(drn_dut, v)) begin
                got_q[v].push_back(obs_flit);
                tag_log.push_back(v);
            end
            if (bitv(acc_dut, v) && src_q[v].size() > 0) void'(src_q[v].pop_front());
        end
        if (rst) begin
            model_reset();
        end else begin
            m_err = 0;
            if (exp_ready != '0) begin
                f = FW'(in_flit >> (w * FW));
                t = f[FW-1 -: TW];
                if (!m_locked) begin
                    if (t == T_HDR) begin
                        m_locked  = 1;
                        m_lock_vc = w;
                    end else if (t == T_PAY || t == T_LAST) begin
                        m_err = 1;
                    end
`ifdef NOC_VC_SCHED_FIXPRIO_EN
                    if (w != 0) m_rr = (w + 1) % N;
`else
                    m_rr = (w + 1) % N;
`endif
                end else begin
                    if (t == T_LAST) m_locked = 0;
                    else if (t == T_HDR || t == T_SGL) m_err = 1;
                end
                m_bvalid = 1;
                m_bvc    = w;
                m_bflit  = f;
            end else if (drain) begin
                m_bvalid = 0;
            end
        end
        #1;
    endtask

    task automatic clear_all();
        for (int v = 0; v < N; v++) begin
            src_q[v].delete();
            sent_q[v].delete();
            got_q[v].delete();
        end
        tag_log.delete();
        exp_tags.delete();
    endtask

    task automatic do_reset();
        clear_all();
        src_en    = '0;
        out_ready = '1;
        rst       = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    function automatic bit busy();
        bit b;
        b = (out_valid != '0);
        for (int v = 0; v < N; v++) begin
            if (bitv(src_en, v) && src_q[v].size() > 0) b = 1;
        end
        return b;
    endfunction

    task automatic drain_all(input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", 64'(busy()), 64'(0));
    endtask

    task automatic compare_order();
        for (int v = 0; v < N; v++) begin
            check($sformatf("count_vc%0d", v), 64'(got_q[v].size()), 64'(sent_q[v].size()));
            for (int i = 0; i < got_q[v].size() && i < sent_q[v].size(); i++) begin
                check($sformatf("order_vc%0d_%0d", v, i), 64'(got_q[v][i]), 64'(sent_q[v][i]));
            end
        end
    endtask

    task automatic check_tags(input string name);
        check({name, "_len"}, 64'(tag_log.size()), 64'(exp_tags.size()));
        for (int i = 0; i < tag_log.size() && i < exp_tags.size(); i++) begin
            check($sformatf("%s_%0d", name, i), 64'(tag_log[i]), 64'(exp_tags[i]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] held;
        int            len;
        logic [1:0]    t;
        model_reset();
        rst       = 1'b1;
        src_en    = '0;
        out_ready = '1;
        in_valid  = '0;
        in_flit   = '0;

        // Reset: outputs quiet even with requests pending
        clear_all();
        for (int v = 0; v < N; v++) enq(v, T_SGL);
        src_en = '1;
        repeat (3) cycle();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(0));
        check("rst_out_flit",  64'(out_flit),  64'(0));
        do_reset();
        drive_inputs();
        #1;
        check("post_rst_in_ready",  64'(in_ready),  64'(0));
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        cycle();

        // Interleave lock: VC1 packet runs contiguously while VC0/VC2 wait
        do_reset();
        enq(1, T_HDR); enq(1, T_PAY); enq(1, T_PAY); enq(1, T_LAST);
        src_en = 3'b010;
        cycle();
        enq(0, T_SGL); enq(2, T_SGL);
        src_en = 3'b111;
        drain_all(50);
`ifdef NOC_VC_SCHED_FIXPRIO_EN
        exp_tags = '{1, 1, 1, 1, 0, 2};
`else
        exp_tags = '{1, 1, 1, 1, 2, 0};
`endif
        check_tags("lock_tags");
        compare_order();

        // Round-robin fairness with everyone offering SINGLE
        do_reset();
        for (int i = 0; i < 4; i++) for (int v = 0; v < N; v++) enq(v, T_SGL);
        src_en = 3'b111;
        drain_all(50);
`ifdef NOC_VC_SCHED_FIXPRIO_EN
        exp_tags = '{0, 0, 0, 0, 1, 2, 1, 2, 1, 2, 1, 2};
`else
        exp_tags = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
`endif
        check_tags("rr_tags");
        compare_order();

        // Backpressure mid-packet on VC1
        do_reset();
        enq(1, T_HDR); enq(1, T_PAY); enq(1, T_PAY); enq(1, T_PAY); enq(1, T_LAST);
        src_en = 3'b010;
        cycle();
        cycle();
        out_ready = 3'b101;
        held = sent_q[1][1];
        repeat (3) begin
            drive_inputs();
            #1;
            check("stall_flit",     64'(out_flit),  64'(held));
            check("stall_valid",    64'(out_valid), 64'(3'b010));
            check("stall_in_ready", 64'(in_ready),  64'(0));
            cycle();
        end
        out_ready = 3'b111;
        drain_all(50);
        compare_order();

        // Protocol error: stray PAYLOAD in idle
        do_reset();
        enq(2, T_PAY);
        src_en = 3'b100;
        cycle();
        check("err_pulse_hi", 64'(err_proto), 64'(1));
        cycle();
        check("err_pulse_lo", 64'(err_proto), 64'(0));
        enq(0, T_SGL); enq(1, T_SGL);
        src_en = 3'b111;
        drive_inputs();
        #1;
        check("err_still_idle", 64'(in_ready), 64'(3'b001));
        drain_all(50);
        compare_order();

        // Reset in the middle of a VC0 packet
        do_reset();
        enq(0, T_HDR); enq(0, T_PAY);
        src_en = 3'b001;
        cycle();
        do_reset();
        enq(2, T_HDR); enq(2, T_LAST);
        src_en = 3'b100;
        drive_inputs();
        #1;
        check("mid_rst_vc2_grant", 64'(in_ready), 64'(3'b100));
        drain_all(50);
        compare_order();
`ifdef NOC_VC_SCHED_FIXPRIO_EN
        do_reset();
        for (int i = 0; i < 4; i++) begin
            enq(0, T_SGL);
            enq(1, T_SGL);
        end
        src_en = 3'b011;
        repeat (4) begin
            drive_inputs();
            #1;
            check("fixprio_vc0", 64'(in_ready), 64'(3'b001));
            cycle();
        end
        drain_all(50);
        compare_order();
`endif

        // Randomized traffic with backpressure and occasional bad flit types
        do_reset();
        repeat (400) begin
            for (int v = 0; v < N; v++) begin
                if (src_q[v].size() == 0 && $urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int i = 0; i < len; i++) begin
                        if (len == 1)          t = T_SGL;
                        else if (i == 0)       t = T_HDR;
                        else if (i == len - 1) t = T_LAST;
                        else                   t = T_PAY;
                        if ($urandom_range(0, 15) == 0) t = 2'($urandom_range(0, 3));
                        enq(v, t);
                    end
                end
            end
            src_en    = N'($urandom);
            out_ready = N'($urandom);
            cycle();
        end
        src_en    = '1;
        out_ready = '1;
        drain_all(500);
        compare_order();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
